// File: rtl/instr_memory_ctrl.sv
// Instruction memory with a byte-lane load port and an in-order fetch port.
// Latency: fetch response 1 cycle after accept (2 with REG_OUT=1); clears all words after reset.
// Backpressure: stall freezes every response stage and deasserts req_ready; nothing is dropped.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   wr_en/wr_addr/wr_data/wr_be    load port (word write with per-byte enables)
//   req_valid/req_addr/req_ready   fetch request handshake
//   stall                          downstream hold
//   rsp_valid/rsp_data/rsp_pc/rsp_fault  fetch response
//   init_done                      memory clear finished
module instr_memory_ctrl #(
   parameter int PC_WIDTH  = 12,
   parameter int OPD_WIDTH = 32,
   parameter int REG_OUT   = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 wr_en,
   input  logic [PC_WIDTH-1:0]  wr_addr,
   input  logic [31:0]          wr_data,
   input  logic [3:0]           wr_be,
   input  logic                 req_valid,
   input  logic [PC_WIDTH-1:0]  req_addr,
   output logic                 req_ready,
   input  logic                 stall,
   output logic                 rsp_valid,
   output logic [31:0]          rsp_data,
   output logic [OPD_WIDTH-1:0] rsp_pc,
   output logic                 rsp_fault,
   output logic                 init_done
);

   localparam int AW      = PC_WIDTH - 2;
   localparam int DEPTH_W = 2 ** AW;

   typedef enum logic {CLEAR, RUN} state_t;

   state_t         state_q;
   logic [AW-1:0]  cnt_q;
   logic           init_done_q;

   // Word-granular load port: the lane bits of the write address carry no meaning.
   logic [1:0]     unused_wr_lane;
   assign unused_wr_lane = wr_addr[1:0];

   // Clear sequencer: one zero word per cycle, then hand the RAM to the load/fetch ports.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= CLEAR;
         cnt_q       <= '0;
         init_done_q <= 1'b0;
      end else if (state_q == CLEAR) begin
         cnt_q <= cnt_q + 1'b1;
         if (&cnt_q) begin
            state_q     <= RUN;
            init_done_q <= 1'b1;
         end
      end
   end

   assign init_done = init_done_q;

   logic accept;
   logic misaligned;
   logic rd_en;

   assign req_ready  = !rst && (state_q == RUN) && !stall;
   assign accept     = req_valid && req_ready;
   assign misaligned = |req_addr[1:0];
   assign rd_en      = accept && !misaligned;

   // Single write port shared between the clear sequencer and the load port.
   logic [3:0]    mem_we;
   logic [AW-1:0] mem_waddr;
   logic [31:0]   mem_wdata;

   always_comb begin
      mem_we    = 4'h0;
      mem_waddr = cnt_q;
      mem_wdata = 32'h0;
      if (!rst) begin
         if (state_q == CLEAR) begin
            mem_we = 4'hF;
         end else if (wr_en) begin
            mem_we    = wr_be;
            mem_waddr = wr_addr[PC_WIDTH-1:2];
            mem_wdata = wr_data;
         end
      end
   end

   // Read-first RAM: a same-cycle write to the fetched word is seen by the next fetch.
   logic [31:0] mem [DEPTH_W];
   logic [31:0] rd_q;

   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (mem_we[i]) mem[mem_waddr][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
      if (rd_en) rd_q <= mem[req_addr[PC_WIDTH-1:2]];
   end

   // First response stage; the RAM output register is its data field.
   logic                s1_vld_q;
   logic                s1_fault_q;
   logic [PC_WIDTH-1:0] s1_pc_q;
   logic [31:0]         s1_data;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_vld_q   <= 1'b0;
         s1_fault_q <= 1'b0;
         s1_pc_q    <= '0;
      end else if (!stall) begin
         s1_vld_q   <= accept;
         s1_fault_q <= accept && misaligned;
         if (accept) s1_pc_q <= req_addr;
      end
   end

   // rd_q has no reset and is not written on faults, so data is masked outside good responses.
   assign s1_data = (s1_vld_q && !s1_fault_q) ? rd_q : 32'h0;

   if (REG_OUT != 0) begin : g_reg_out
      logic                 s2_vld_q;
      logic                 s2_fault_q;
      logic [31:0]          s2_data_q;
      logic [OPD_WIDTH-1:0] s2_pc_q;

      always_ff @(posedge clk) begin
         if (rst) begin
            s2_vld_q   <= 1'b0;
            s2_fault_q <= 1'b0;
            s2_data_q  <= 32'h0;
            s2_pc_q    <= '0;
         end else if (!stall) begin
            s2_vld_q   <= s1_vld_q;
            s2_fault_q <= s1_fault_q;
            s2_data_q  <= s1_data;
            s2_pc_q    <= OPD_WIDTH'(s1_pc_q);
         end
      end

      assign rsp_valid = s2_vld_q;
      assign rsp_fault = s2_fault_q;
      assign rsp_data  = s2_data_q;
      assign rsp_pc    = s2_pc_q;
   end else begin : g_comb_out
      assign rsp_valid = s1_vld_q;
      assign rsp_fault = s1_fault_q;
      assign rsp_data  = s1_data;
      assign rsp_pc    = OPD_WIDTH'(s1_pc_q);
   end

endmodule

// File: tb/tb_instr_memory_ctrl.sv
// Directed bench for instr_memory_ctrl (PC_WIDTH=12, REG_OUT=0).
// Drives inputs 1ns after each rising edge and samples outputs at the same point.
// Expected values are hand-computed constants.
module tb_instr_memory_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        wr_en;
   logic [11:0] wr_addr;
   logic [31:0] wr_data;
   logic [3:0]  wr_be;
   logic        req_valid;
   logic [11:0] req_addr;
   logic        req_ready;
   logic        stall;
   logic        rsp_valid;
   logic [31:0] rsp_data;
   logic [31:0] rsp_pc;
   logic        rsp_fault;
   logic        init_done;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   instr_memory_ctrl #(
      .PC_WIDTH (12),
      .OPD_WIDTH(32),
      .REG_OUT  (0)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .wr_be    (wr_be),
      .req_valid(req_valid),
      .req_addr (req_addr),
      .req_ready(req_ready),
      .stall    (stall),
      .rsp_valid(rsp_valid),
      .rsp_data (rsp_data),
      .rsp_pc   (rsp_pc),
      .rsp_fault(rsp_fault),
      .init_done(init_done)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_word(input logic [11:0] a, input logic [31:0] d, input logic [3:0] be);
      wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
      tick();
      wr_en = 1'b0;
   endtask

   // Issues one fetch; on return the response for it is on the outputs.
   task automatic fetch(input logic [11:0] a);
      req_valid = 1'b1; req_addr = a;
      tick();
      req_valid = 1'b0;
   endtask

   // Counts edges until init_done, flagging any ready/valid seen during the clear.
   task automatic wait_init(output int n, output logic rdy_seen, output logic vld_seen);
      n = 0; rdy_seen = 1'b0; vld_seen = 1'b0;
      while (!init_done && n < 2000) begin
         if (req_ready) rdy_seen = 1'b1;
         if (rsp_valid) vld_seen = 1'b1;
         tick();
         n++;
      end
   endtask

   initial begin
      int   n;
      logic rdy_seen;
      logic vld_seen;

      rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
      req_valid = 1'b0; req_addr = '0; stall = 1'b0;
      repeat (3) tick();

      chk("rst_rsp_valid", rsp_valid, 1'b0);
      chk("rst_rsp_data",  rsp_data,  32'h0);
      chk("rst_rsp_pc",    rsp_pc,    32'h0);
      chk("rst_rsp_fault", rsp_fault, 1'b0);
      chk("rst_req_ready", req_ready, 1'b0);
      chk("rst_init_done", init_done, 1'b0);

      // Clear phase with hostile traffic: a load to word 0 and a fetch, both to be ignored.
      rst = 1'b0;
      wr_en = 1'b1; wr_addr = 12'h000; wr_data = 32'hFFFF_FFFF; wr_be = 4'hF;
      req_valid = 1'b1; req_addr = 12'h000;
      wait_init(n, rdy_seen, vld_seen);
      wr_en = 1'b0; req_valid = 1'b0;
      chk("init_cycles",       n, 1024);
      chk("clear_req_ready",   rdy_seen, 1'b0);
      chk("clear_rsp_valid",   vld_seen, 1'b0);
      chk("run_req_ready",     req_ready, 1'b1);

      fetch(12'h000);
      chk("clr0_valid", rsp_valid, 1'b1);
      chk("clr0_data",  rsp_data,  32'h0000_0000);

      // Full-word load and fetch.
      write_word(12'h000, 32'h0041_8133, 4'hF);
      fetch(12'h000);
      chk("ld0_valid", rsp_valid, 1'b1);
      chk("ld0_data",  rsp_data,  32'h0041_8133);
      chk("ld0_pc",    rsp_pc,    32'h0);
      chk("ld0_fault", rsp_fault, 1'b0);
      tick();
      chk("idle_valid", rsp_valid, 1'b0);

      // Partial-lane write: lanes 0 and 2 replaced.
      write_word(12'h010, 32'hAABB_CCDD, 4'hF);
      write_word(12'h010, 32'h1122_3344, 4'b0101);
      fetch(12'h010);
      chk("be_data", rsp_data, 32'hAA22_CC44);

      // Misaligned fetch followed back-to-back by an aligned one.
      req_valid = 1'b1; req_addr = 12'h006;
      tick();
      chk("mis_valid", rsp_valid, 1'b1);
      chk("mis_fault", rsp_fault, 1'b1);
      chk("mis_data",  rsp_data,  32'h0);
      chk("mis_pc",    rsp_pc,    32'h6);
      req_addr = 12'h008;
      tick();
      chk("b2b_fault", rsp_fault, 1'b0);
      chk("b2b_pc",    rsp_pc,    32'h8);
      chk("b2b_data",  rsp_data,  32'h0);
      req_addr = 12'h011;
      tick();
      req_valid = 1'b0;
      chk("mis2_fault", rsp_fault, 1'b1);
      chk("mis2_data",  rsp_data,  32'h0);

      // Stream with a 3-cycle stall after the first response.
      write_word(12'h004, 32'hCAFE_F00D, 4'hF);
      write_word(12'h008, 32'h0BAD_C0DE, 4'hF);
      req_valid = 1'b1; req_addr = 12'h000;
      tick();
      chk("st0_data", rsp_data, 32'h0041_8133);
      stall = 1'b1; req_addr = 12'h004;
      #1;
      chk("st_req_ready", req_ready, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("st_hold_valid", rsp_valid, 1'b1);
         chk("st_hold_data",  rsp_data,  32'h0041_8133);
         chk("st_hold_pc",    rsp_pc,    32'h0);
      end
      stall = 1'b0;
      tick();
      chk("st1_data", rsp_data, 32'hCAFE_F00D);
      chk("st1_pc",   rsp_pc,   32'h4);
      req_addr = 12'h008;
      tick();
      req_valid = 1'b0;
      chk("st2_data", rsp_data, 32'h0BAD_C0DE);
      chk("st2_pc",   rsp_pc,   32'h8);
      tick();
      chk("st_end_valid", rsp_valid, 1'b0);

      // Read-first on a same-cycle write and fetch.
      write_word(12'h020, 32'hDEAD_BEEF, 4'hF);
      wr_en = 1'b1; wr_addr = 12'h020; wr_data = 32'h1234_5678; wr_be = 4'hF;
      req_valid = 1'b1; req_addr = 12'h020;
      tick();
      wr_en = 1'b0;
      chk("rf_old", rsp_data, 32'hDEAD_BEEF);
      tick();
      chk("rf_new", rsp_data, 32'h1234_5678);

      // Reset with a fetch in flight and another being requested.
      chk("mid_valid", rsp_valid, 1'b1);
      rst = 1'b1;
      tick();
      chk("mrst_valid",     rsp_valid, 1'b0);
      chk("mrst_data",      rsp_data,  32'h0);
      chk("mrst_pc",        rsp_pc,    32'h0);
      chk("mrst_req_ready", req_ready, 1'b0);
      chk("mrst_init_done", init_done, 1'b0);
      rst = 1'b0; req_valid = 1'b0;
      wait_init(n, rdy_seen, vld_seen);
      chk("reinit_cycles", n, 1024);
      fetch(12'h020);
      chk("reinit_data20", rsp_data, 32'h0);
      fetch(12'h000);
      chk("reinit_data0", rsp_data, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/instr_memory_ctrl.md
INSTR_MEMORY_CTRL -- requirements
Module: instr_memory_ctrl

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 12: byte-address width; capacity is 2**PC_WIDTH bytes, organised as DEPTH_W = 2**(PC_WIDTH-2) words of 32 bits.
REQ-002 SHALL have parameter OPD_WIDTH, default 32: width of rsp_pc, zero-extended from the address.
REQ-003 SHALL have parameter REG_OUT, default 0: 0 = fetch latency 1 cycle; 1 = extra output register, fetch latency 2 cycles.
REQ-004 SHALL use reset rst, synchronous, active-high, and clock clk.
REQ-005 SHALL have these ports, clock and reset first:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- wr_en  input  1  load-port write strobe
- wr_addr  input  PC_WIDTH  load-port byte address; bits [1:0] are ignored
- wr_data  input  32  load-port word, little-endian
- wr_be  input  4  byte-lane enables; bit n enables wr_data[8n+7:8n]
- req_valid  input  1  fetch request
- req_addr  input  PC_WIDTH  fetch byte address
- req_ready  output  1  fetch request can be accepted
- stall  input  1  downstream hold
- rsp_valid  output  1  fetch response valid
- rsp_data  output  32  fetched instruction, little-endian
- rsp_pc  output  OPD_WIDTH  address of the fetched instruction
- rsp_fault  output  1  misaligned fetch
- init_done  output  1  memory clear complete

Function
REQ-006 SHALL implement a two-state FSM with states CLEAR and RUN; reset enters CLEAR with the word counter at 0.
REQ-007 In CLEAR, the block SHALL write 0 to word[counter] every cycle and then increment the counter; after the write to word DEPTH_W-1 it SHALL go to RUN, and init_done SHALL be 1 from the next cycle.
REQ-008 In CLEAR, req_ready SHALL be 0 and load-port writes SHALL be ignored.
REQ-009 In RUN, req_ready SHALL equal !stall; a fetch is accepted on a cycle where req_valid and req_ready are both 1.
REQ-010 Byte address a SHALL map to word a[PC_WIDTH-1:2], lane a[1:0]; rsp_data SHALL be {byte3, byte2, byte1, byte0}.
REQ-011 For an accepted fetch at cycle N, rsp_valid SHALL be 1 at N+1 (REG_OUT=0) or N+2 (REG_OUT=1), with rsp_pc = req_addr.
REQ-012 An accepted fetch with req_addr[1:0] != 0 SHALL produce rsp_fault=1 and rsp_data=0, and SHALL NOT use the memory read.
REQ-013 With no fetch accepted and stall=0, rsp_valid SHALL drop to 0 on the following response slot.
REQ-014 While stall=1, all rsp_* outputs and every pipeline stage SHALL hold their values, and no request SHALL be accepted.
REQ-015 In RUN, wr_en=1 SHALL write the enabled lanes of word wr_addr[PC_WIDTH-1:2] at the clock edge; disabled lanes SHALL keep their values.
REQ-016 A write and a fetch to the same word in the same cycle SHALL be read-first: the fetch returns the old data, and the new data is visible from the next fetch.
REQ-017 Storage SHALL be a single-read, single-write synchronous RAM that infers block RAM; there SHALL be no per-entry reset loop.

Reset
REQ-018 On rst=1 the block SHALL set rsp_valid=0, rsp_data=0, rsp_pc=0, rsp_fault=0, req_ready=0, init_done=0, counter=0, and state=CLEAR.
REQ-019 Reset mid-operation SHALL discard in-flight fetches and restart CLEAR from word 0; memory contents SHALL NOT be preserved.
REQ-020 rst SHALL take priority over wr_en, req_valid and stall.

Verification
REQ-021 Reset then idle, PC_WIDTH=12 -> init_done rises exactly 1024 cycles after rst falls; req_ready is 0 throughout; a fetch at 0x0 afterwards returns 0x00000000.
REQ-022 Load 0x00418133 at 0x000 with wr_be=4'hF, then fetch 0x000 -> rsp_data=0x00418133, rsp_pc=0, rsp_fault=0, 1 cycle after accept (2 cycles if REG_OUT=1).
REQ-023 Load 0xAABBCCDD at 0x010, then write 0x11223344 with wr_be=4'b0101, then fetch 0x010 -> 0xAA22CC44.
REQ-024 Fetch 0x006 -> rsp_fault=1, rsp_data=0, rsp_pc=6; a back-to-back fetch at 0x008 -> rsp_fault=0.
REQ-025 Stream of fetches 0x0, 0x4, 0x8 with stall=1 for 3 cycles after the first response -> that response is held, req_ready=0, and there are no lost or duplicated responses.
REQ-026 Same-cycle write 0x12345678 and fetch at 0x020 holding 0xDEADBEEF -> returns 0xDEADBEEF; the next fetch returns 0x12345678. Assert rst mid-stream -> rsp_valid=0 the next cycle and CLEAR restarts.
